// File: rtl/homomorphic_add.sv
// Registered modular add of two LWE ciphertext scalars, result canonical in [0, Q).
// Define HOMOMORPHIC_ADD_REDUCE_EN for full mod-Q reduction; otherwise the raw truncated sum is registered.
module homomorphic_add #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 21,
  parameter int DIMENSION          = 1,
  parameter int BIG_N              = 30
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic signed [CIPHERTEXT_WIDTH-1:0] ciphertext1,
  input  logic signed [CIPHERTEXT_WIDTH-1:0] ciphertext2,
  output logic signed [CIPHERTEXT_WIDTH-1:0] result
);

  localparam int W = CIPHERTEXT_WIDTH;

  // Plaintext/LWE-shape parameters only travel with the interface in this scalar revision.
  logic unused_params;
  assign unused_params = ^{32'(PLAINTEXT_MODULUS), 32'(PLAINTEXT_WIDTH), 32'(DIMENSION),
                           32'(BIG_N), 32'(CIPHERTEXT_MODULUS)};

  logic signed [W-1:0] result_d, result_q;

`ifdef HOMOMORPHIC_ADD_REDUCE_EN
  localparam logic signed [W:0] Q = (W+1)'(CIPHERTEXT_MODULUS);

  // One conditional add/subtract of Q; exact for operands in [-Q, 2Q).
  function automatic logic signed [W:0] canon(input logic signed [W:0] x);
    if (x < 0)        canon = x + Q;
    else if (x >= Q)  canon = x - Q;
    else              canon = x;
  endfunction

  logic signed [W:0] a_c, b_c, sum, sum_red;

  always_comb begin
    a_c     = canon({ciphertext1[W-1], ciphertext1});
    b_c     = canon({ciphertext2[W-1], ciphertext2});
    // W+1 bits holds any pair of canonicalised W-bit operands without overflow.
    sum     = a_c + b_c;
    sum_red = (sum >= Q) ? sum - Q : sum;
    result_d = sum_red[W-1:0];
  end
`else
  always_comb begin
    result_d = ciphertext1 + ciphertext2;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result_q <= '0;
    else        result_q <= result_d;
  end

  assign result = result_q;

endmodule

// File: tb/tb_homomorphic_add.sv
// Directed bench for homomorphic_add (Q=1024, W=21); expectations follow HOMOMORPHIC_ADD_REDUCE_EN.
module tb_homomorphic_add;
  localparam int W = 21;

`ifdef HOMOMORPHIC_ADD_REDUCE_EN
  localparam bit RED = 1'b1;
`else
  localparam bit RED = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic signed [W-1:0] ct1 = '0, ct2 = '0;
  logic signed [W-1:0] res;

  int checks = 0;
  int failures = 0;

  homomorphic_add #(
    .PLAINTEXT_MODULUS(64), .PLAINTEXT_WIDTH(6), .CIPHERTEXT_MODULUS(1024),
    .CIPHERTEXT_WIDTH(W), .DIMENSION(1), .BIG_N(30)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ciphertext1(ct1), .ciphertext2(ct2), .result(res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [W-1:0] got,
                     input logic signed [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive away from the edge, then sample just after the capturing edge.
  task automatic cyc(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    @(negedge clk);
    ct1 = a;
    ct2 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Async reset before any clock edge (first posedge at t=5).
    #1;
    ct1 = 21'sd7; ct2 = 21'sd9;
    rst_n = 1'b0;
    #1;
    chk("reset_async", res, 21'sd0);
    @(posedge clk); #1;
    chk("reset_hold", res, 21'sd0);

    @(negedge clk);
    ct1 = 21'sd102; ct2 = 21'sd356;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_102_356", res, 21'sd458);

    cyc(21'sd1000, 21'sd100);
    chk("wrap_1000_100", res, RED ? 21'sd76 : 21'sd1100);

    cyc(21'sd1023, 21'sd1023);
    chk("max_max", res, RED ? 21'sd1022 : 21'sd2046);

    cyc(-21'sd5, 21'sd10);
    chk("neg_op", res, 21'sd5);

    cyc(21'sd1024, 21'sd0);
    chk("q_plus_0", res, RED ? 21'sd0 : 21'sd1024);

    cyc(-21'sd1024, -21'sd1);
    chk("neg_edge", res, RED ? 21'sd1023 : -21'sd1025);

    cyc(21'sd2047, 21'sd2047);
    chk("top_edge", res, RED ? 21'sd1022 : 21'sd4094);

    // Outside [-Q,2Q): single-step canonicalisation, 5000-1024=3976, then 3976-1024=2952.
    cyc(21'sd5000, 21'sd0);
    chk("out_of_range", res, RED ? 21'sd2952 : 21'sd5000);

    cyc(21'sd1, 21'sd2);
    chk("b2b_first", res, 21'sd3);
    cyc(21'sd3, 21'sd4);
    chk("b2b_second", res, 21'sd7);

    // Mid-stream reset pulse.
    @(negedge clk);
    ct1 = 21'sd10; ct2 = 21'sd20;
    #2;
    rst_n = 1'b0;
    #1;
    chk("pulse_async", res, 21'sd0);
    @(posedge clk); #1;
    chk("pulse_hold", res, 21'sd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("pulse_release", res, 21'sd30);

    // Reset asserted on the clock edge itself.
    cyc(21'sd100, 21'sd200);
    chk("pre_sim", res, 21'sd300);
    @(negedge clk);
    ct1 = 21'sd50; ct2 = 21'sd60;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("sim_edge_reset", res, 21'sd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("sim_release", res, 21'sd110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end
endmodule
